keypad_scan_ctrl: RTL and testbench

- Sequencer for a 4x4 matrix keypad.
- Consumes the single-cycle scan tick from the clock divider and drives one keypad column low per tick.
- Debounces presses and releases, then hands a 4-bit key code to downstream display/logic through a valid/ack handshake.
- Sits between the divider and the project's display/control datapath.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_debounce.sv | 46 ++++
 rtl/keypad_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, sizes and helpers for the 4x4 keypad scanner.
//   state_t    : scanner FSM states
//   key_code_t : emitted key code payload, {row, col}, i.e. row*4 + col
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int unsigned IDX_W    = $clog2(NUM_ROWS);
  localparam int unsigned CODE_W   = $clog2(NUM_KEYS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
  } key_code_t;

  // Counter width: clog2 of the largest count needed (at least 1), plus one.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = 1;
    if (a > m) m = a;
    if (b > m) m = b;
    return $clog2(m) + 1;
  endfunction

  // Index of the lowest-numbered active-low row.
  function automatic logic [IDX_W-1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = int'(NUM_ROWS) - 1; i >= 0; i--) begin
      if (!rows_n[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: saturating tick counter shared by press and release debouncing.
//   clk, rst_n : clock, async active-low reset
//   tick       : scan tick; the counter only moves on ticks
//   clear      : restart the run (the current tick counts as the first sample)
//   agree      : current tick sample agrees with the run; count it
//   done       : registered; the next agreeing tick completes a TICKS-long run
module keypad_debounce #(
  parameter int unsigned TICKS = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic clear,
  input  logic agree,
  output logic done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart at 1 on clear, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (tick) begin
      if (clear) begin
        cnt_d = CNT_W'(1);
      end else if (agree && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      done  <= (cnt_d >= LAST);
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner with debounce and valid/ack output.
//   clk, rst_n : clock, async active-low reset
//   tick       : one-cycle scan enable from the divider
//   row_n      : raw active-low rows (asynchronous)
//   col_n      : one-hot active-low column drive
//   key_code   : row*4 + col of the pending key
//   key_valid  : a code is pending until key_ack
//   key_ack    : consumer accepts the pending code
//   overrun    : one-cycle pulse when an emission is dropped
// Optional: define KEYPAD_REPEAT_EN for auto-repeat every REPEAT_TICKS while held.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_TICKS   = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [NUM_ROWS-1:0] row_n,
  output logic [NUM_COLS-1:0] col_n,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  input  logic                key_ack,
  output logic                overrun
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_TICKS, REPEAT_TICKS);
  localparam bit          FAST  = (DEBOUNCE_TICKS <= 1);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  state_t              state_q;
  state_t              state_d;
  logic [IDX_W-1:0]    col_q;
  logic [IDX_W-1:0]    row_q;
  logic [IDX_W-1:0]    col_nx_c;
  logic [IDX_W-1:0]    det_row_c;
  logic                rows_idle_c;
  logic                row_hit_c;
  logic                db_done;
  logic                adv_c;
  logic                det_c;
  logic                emit_c;
  logic                db_clear_c;
  logic                db_agree_c;
  logic                fire_c;
  key_code_t           code_c;

  // Two-flop synchronizer; rows idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  assign rows_idle_c = &row_sync;
  assign row_hit_c   = ~row_sync[row_q];
  assign det_row_c   = lowest_low_row(row_sync);
  assign col_nx_c    = col_q + IDX_W'(1);

  // In SCAN the row is not latched yet, so the immediate-emit path uses the live detection.
  assign code_c.row = (state_q == SCAN) ? det_row_c : row_q;
  assign code_c.col = col_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SCAN;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        SCAN:     if (!rows_idle_c) state_d = FAST ? PRESSED : DEBOUNCE;
        DEBOUNCE: if (!row_hit_c)   state_d = SCAN;
                  else if (db_done) state_d = PRESSED;
        PRESSED:  if (!row_hit_c)   state_d = FAST ? SCAN : RELEASE;
        RELEASE:  if (row_hit_c)    state_d = PRESSED;
                  else if (db_done) state_d = SCAN;
        default:  state_d = SCAN;
      endcase
    end
  end

  // Per-tick control strobes.
  always_comb begin
    adv_c      = 1'b0;
    det_c      = 1'b0;
    emit_c     = 1'b0;
    db_clear_c = 1'b0;
    db_agree_c = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (rows_idle_c) begin
            adv_c = 1'b1;
          end else begin
            det_c      = 1'b1;
            emit_c     = FAST;
            db_clear_c = !FAST;
          end
        end
        DEBOUNCE: begin
          db_agree_c = row_hit_c;
          emit_c     = row_hit_c && db_done;
        end
        PRESSED: begin
          if (!row_hit_c) begin
            adv_c      = FAST;
            db_clear_c = !FAST;
          end
        end
        RELEASE: begin
          db_agree_c = !row_hit_c;
          adv_c      = !row_hit_c && db_done;
        end
        default: ;
      endcase
    end
  end

  keypad_debounce #(
    .TICKS (DEBOUNCE_TICKS),
    .CNT_W (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .clear (db_clear_c),
    .agree (db_agree_c),
    .done  (db_done)
  );

`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0] rpt_q;
  logic             rpt_inc_c;
  logic             rpt_clr_c;

  // Repeat counter runs only while the key stays down in PRESSED.
  assign rpt_inc_c = tick && (state_q == PRESSED) && row_hit_c;
  assign rpt_clr_c = (state_d == PRESSED) && (state_q != PRESSED);
  assign fire_c    = rpt_inc_c && (rpt_q >= CNT_W'(REPEAT_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else if (rpt_clr_c || fire_c) begin
      rpt_q <= '0;
    end else if (rpt_inc_c && (rpt_q != '1)) begin
      rpt_q <= rpt_q + CNT_W'(1);
    end
  end
`else
  assign fire_c = 1'b0;
`endif

  // Column/row tracking and the valid/ack output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      col_n     <= 4'b1110;
      key_code  <= '0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (adv_c) begin
        col_q <= col_nx_c;
        col_n <= ~(NUM_COLS'(1) << col_nx_c);
      end
      if (det_c) row_q <= det_row_c;
      if (emit_c || fire_c) begin
        // An ack in the emit cycle frees the slot for the new code.
        if (!key_valid || key_ack) begin
          key_code  <= code_c;
          key_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: randomized scenario bench for keypad_scan_ctrl with a
// behavioural keypad (one key, optional bounce) and a tick-level expectation model.
module tb_keypad_scan_ctrl;

  localparam int unsigned DB       = 4;
  localparam int unsigned RPT      = 2;
  localparam int unsigned TICK_GAP = 8;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       tick    = 1'b0;
  logic       key_ack = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       overrun;

  logic       key_on = 1'b0;
  logic [1:0] key_r  = 2'd0;
  logic [1:0] key_c  = 2'd0;

  int n_pass  = 0;
  int n_total = 0;
  int exp_c   = 0;
  int ovr_cnt = 0;

  always #5 clk = ~clk;

  // One physical key: its row reads low only while its column is driven.
  assign row_n = (key_on && !col_n[key_c]) ? ~(4'b0001 << key_r) : 4'b1111;

  always @(negedge clk) if (overrun === 1'b1) ovr_cnt++;

  keypad_scan_ctrl #(
    .DEBOUNCE_TICKS (DB),
    .REPEAT_TICKS   (RPT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .overrun   (overrun)
  );

  function automatic logic [3:0] col_of(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  // One tick, spaced so the synchronized rows settle; returns at the negedge after it.
  task automatic step();
    repeat (TICK_GAP - 1) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic step_ack();
    repeat (TICK_GAP - 1) @(negedge clk);
    tick    = 1'b1;
    key_ack = 1'b1;
    @(negedge clk);
    tick    = 1'b0;
    key_ack = 1'b0;
  endtask

  task automatic advance_to(input int c);
    key_on = 1'b0;
    while (exp_c != c) begin
      step();
      exp_c = (exp_c + 1) % 4;
    end
  endtask

  task automatic ack_and_release(input int c);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    n_total++;
    if (key_valid !== 1'b0) $display("FAIL ack_drop: key_valid got %b want 0", key_valid);
    else n_pass++;
    key_on = 1'b0;
    for (int k = 1; k <= int'(DB); k++) begin
      step();
      n_total++;
      if (k < int'(DB) && col_n !== col_of(c))
        $display("FAIL release_hold: col_n got %b want %b", col_n, col_of(c));
      else if (k == int'(DB) && col_n !== col_of((c + 1) % 4))
        $display("FAIL release_adv: col_n got %b want %b", col_n, col_of((c + 1) % 4));
      else n_pass++;
    end
    exp_c = (c + 1) % 4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (col_n !== 4'b1110) $display("FAIL reset_col: got %b want 1110", col_n);
    else n_pass++;
    n_total++;
    if (key_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", key_valid);
    else n_pass++;
    n_total++;
    if (key_code !== 4'd0) $display("FAIL reset_code: got %0d want 0", key_code);
    else n_pass++;
    n_total++;
    if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    exp_c = 0;
  endtask

  task automatic test_scan();
    for (int t = 0; t < 8; t++) begin
      key_ack = 1'($urandom_range(0, 1));
      step();
      key_ack = 1'b0;
      exp_c = (exp_c + 1) % 4;
      n_total++;
      if (col_n !== col_of(exp_c) || key_valid !== 1'b0)
        $display("FAIL scan_step: col_n=%b valid=%b want col_n=%b valid=0",
                 col_n, key_valid, col_of(exp_c));
      else n_pass++;
    end
  endtask

  task automatic test_press(input int iters);
    int r, c, hold, ovr0;
    for (int it = 0; it < iters; it++) begin
      r = (it == 0) ? 2 : int'($urandom_range(0, 3));
      c = (it == 0) ? 1 : int'($urandom_range(0, 3));
      ovr0 = ovr_cnt;
      advance_to(c);
      key_r = 2'(r); key_c = 2'(c); key_on = 1'b1;
      for (int k = 1; k <= int'(DB); k++) begin
        step();
        n_total++;
        if (k < int'(DB) && (key_valid !== 1'b0 || col_n !== col_of(c)))
          $display("FAIL press_wait: tick %0d valid=%b col_n=%b want 0/%b", k, key_valid, col_n, col_of(c));
        else if (k == int'(DB) && (key_valid !== 1'b1 || key_code !== 4'(r * 4 + c)))
          $display("FAIL press_emit: valid=%b code=%0d want 1/%0d", key_valid, key_code, r * 4 + c);
        else n_pass++;
      end
      hold = REP ? 0 : int'($urandom_range(0, 5));
      repeat (hold) begin
        step();
        n_total++;
        if (key_valid !== 1'b1 || key_code !== 4'(r * 4 + c))
          $display("FAIL press_hold: valid=%b code=%0d want 1/%0d", key_valid, key_code, r * 4 + c);
        else n_pass++;
      end
      ack_and_release(c);
      n_total++;
      if (ovr_cnt !== ovr0) $display("FAIL press_no_ovr: pulses got %0d want 0", ovr_cnt - ovr0);
      else n_pass++;
    end
  endtask

  task automatic test_bounce(input int iters);
    int r, c, a;
    for (int it = 0; it < iters; it++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      a = int'($urandom_range(1, DB - 1));
      advance_to(c);
      key_r = 2'(r); key_c = 2'(c); key_on = 1'b1;
      repeat (a) step();
      key_on = 1'b0;
      step();
      n_total++;
      if (key_valid !== 1'b0 || col_n !== col_of(c))
        $display("FAIL bounce_gap: valid=%b col_n=%b want 0/%b", key_valid, col_n, col_of(c));
      else n_pass++;
      key_on = 1'b1;
      for (int k = 1; k <= int'(DB); k++) begin
        step();
        n_total++;
        if (k < int'(DB) && key_valid !== 1'b0)
          $display("FAIL bounce_early: tick %0d valid=%b want 0", k, key_valid);
        else if (k == int'(DB) && (key_valid !== 1'b1 || key_code !== 4'(r * 4 + c)))
          $display("FAIL bounce_emit: valid=%b code=%0d want 1/%0d", key_valid, key_code, r * 4 + c);
        else n_pass++;
      end
      ack_and_release(c);
    end
  endtask

  task automatic test_overrun();
    int r, c, ovr0;
    ovr0 = ovr_cnt;
    // First press (code 9) left pending.
    advance_to(1);
    key_r = 2'd2; key_c = 2'd1; key_on = 1'b1;
    repeat (DB) step();
    key_on = 1'b0;
    repeat (DB) step();
    exp_c = 2;
    n_total++;
    if (key_valid !== 1'b1 || key_code !== 4'd9)
      $display("FAIL ovr_pending: valid=%b code=%0d want 1/9", key_valid, key_code);
    else n_pass++;
    // Second press (code 3) without ack is dropped.
    advance_to(3);
    key_r = 2'd0; key_c = 2'd3; key_on = 1'b1;
    repeat (DB) step();
    n_total++;
    if (overrun !== 1'b1 || key_code !== 4'd9 || key_valid !== 1'b1)
      $display("FAIL ovr_pulse: ovr=%b code=%0d valid=%b want 1/9/1", overrun, key_code, key_valid);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (overrun !== 1'b0) $display("FAIL ovr_single: got %b want 0", overrun);
    else n_pass++;
    key_on = 1'b0;
    repeat (DB) step();
    exp_c = 0;
    // Third press acked in its emit cycle replaces the code.
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    advance_to(c);
    key_r = 2'(r); key_c = 2'(c); key_on = 1'b1;
    repeat (DB - 1) step();
    step_ack();
    n_total++;
    if (key_code !== 4'(r * 4 + c) || key_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL ack_on_emit: code=%0d valid=%b ovr=%b want %0d/1/0",
               key_code, key_valid, overrun, r * 4 + c);
    else n_pass++;
    ack_and_release(c);
    n_total++;
    if (ovr_cnt - ovr0 !== 1) $display("FAIL ovr_count: pulses got %0d want 1", ovr_cnt - ovr0);
    else n_pass++;
  endtask

  task automatic test_repeat();
    int r, c, emits, want, ovr0;
    r = int'($urandom_range(0, 3));
    c = int'($urandom_range(0, 3));
    advance_to(c);
    ovr0  = ovr_cnt;
    emits = 0;
    key_r = 2'(r); key_c = 2'(c); key_on = 1'b1;
    // Hold DB ticks to accept, then 10 more ticks; ack every emission promptly.
    for (int t = 0; t < int'(DB) + 10; t++) begin
      for (int cyc = 0; cyc < int'(TICK_GAP); cyc++) begin
        @(negedge clk);
        if (key_valid === 1'b1 && key_ack === 1'b0) begin
          emits++;
          key_ack = 1'b1;
        end else begin
          key_ack = 1'b0;
        end
        tick = (cyc == int'(TICK_GAP) - 1);
      end
    end
    @(negedge clk);
    tick = 1'b0;
    if (key_valid === 1'b1 && key_ack === 1'b0) emits++;
    key_ack = key_valid;
    @(negedge clk);
    key_ack = 1'b0;
    want = 1 + (REP ? 10 / int'(RPT) : 0);
    n_total++;
    if (emits !== want) $display("FAIL repeat_count: emissions got %0d want %0d", emits, want);
    else n_pass++;
    n_total++;
    if (ovr_cnt !== ovr0) $display("FAIL repeat_no_ovr: pulses got %0d want 0", ovr_cnt - ovr0);
    else n_pass++;
    key_on = 1'b0;
    repeat (DB) step();
    exp_c = (c + 1) % 4;
  endtask

  task automatic test_reset_mid();
    int c, c2;
    c = int'($urandom_range(0, 3));
    advance_to(c);
    key_r = 2'(int'($urandom_range(0, 3))); key_c = 2'(c); key_on = 1'b1;
    repeat (DB) step();
    key_on = 1'b0;
    repeat (DB) step();
    exp_c = (c + 1) % 4;
    c2 = int'($urandom_range(0, 3));
    advance_to(c2);
    key_c = 2'(c2); key_on = 1'b1;
    repeat (2) step();
    n_total++;
    if (key_valid !== 1'b1 || col_n !== col_of(c2))
      $display("FAIL mid_pre: valid=%b col_n=%b want 1/%b", key_valid, col_n, col_of(c2));
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if (col_n !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 || overrun !== 1'b0)
      $display("FAIL mid_reset: col_n=%b valid=%b code=%0d ovr=%b want 1110/0/0/0",
               col_n, key_valid, key_code, overrun);
    else n_pass++;
    key_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_c = 0;
    step();
    exp_c = 1;
    n_total++;
    if (col_n !== col_of(1) || key_valid !== 1'b0)
      $display("FAIL mid_restart: col_n=%b valid=%b want %b/0", col_n, key_valid, col_of(1));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press(6);
    test_bounce(4);
    test_overrun();
    test_repeat();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
